gamma_lut_loader: RTL

- Transmitter end of the gamma LUT loading-packet interface (SOP/EOP/VLD/packet_data) consumed by the gamma correction block.
- Accepts the byte stream of an I2C slave front end and captures one complete 256-entry gamma table into an internal shadow RAM.
- Validates the frame; only a good frame is replayed as one contiguous 256-beat packet. A truncated or corrupted I2C transfer therefore never reaches the live LUTs.

---
 rtl/gamma_pkg.sv | 17 +
 rtl/gamma_shadow_ram.sv | 25 ++
 rtl/gamma_lut_loader.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/gamma_pkg.sv
// Shared constants and FSM state type for the gamma LUT loader.
package gamma_pkg;

  localparam int         LUT_DEPTH    = 256;
  localparam int         LUT_AW       = 8;
  localparam logic [7:0] DEF_CMD_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    DATA,
    CHK,
    WAIT_STOP,
    TX
  } state_e;

endpackage

// File: rtl/gamma_shadow_ram.sv
// 256x8 simple dual-port shadow RAM: one write port, one registered read port.
module gamma_shadow_ram
  import gamma_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [LUT_AW-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              rd_en,
  input  logic [LUT_AW-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem_q [LUT_DEPTH];
  logic [7:0] rd_data_q;

  // Contents are deliberately not reset; only a committed frame is ever read.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/gamma_lut_loader.sv
// Captures a 256-entry gamma table from an I2C byte stream and replays a good frame
// as one SOP/EOP/VLD packet. Optional trailing checksum byte: `define GAMMA_LUT_CHKSUM_EN.
//
// state     | meaning
// IDLE      | waiting for I2C start
// CMD       | expecting the command byte
// DATA      | writing table entries into shadow RAM
// CHK       | expecting checksum byte (checksum build only)
// WAIT_STOP | full table received, waiting for I2C stop to commit
// TX        | replaying shadow RAM as a 256-beat packet
module gamma_lut_loader
  import gamma_pkg::*;
#(
  parameter logic [7:0] CMD_BYTE = DEF_CMD_BYTE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_start,
  input  logic       rx_stop,
  input  logic       rx_vld,
  input  logic [7:0] rx_byte,
  output logic       SOP,
  output logic       EOP,
  output logic       VLD,
  output logic [7:0] packet_data,
  output logic       busy,
  output logic       load_done,
  output logic       load_err
);

  localparam logic [8:0] CNT_LAST = 9'(LUT_DEPTH - 1);

  state_e      state_q, state_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        rd_vld_q, rd_vld_d, rd_sop_q, rd_sop_d, rd_eop_q, rd_eop_d;
  logic        sop_q, sop_d, eop_q, eop_d, vld_q, vld_d;
  logic [7:0]  pkt_q, pkt_d;
  logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
`ifdef GAMMA_LUT_CHKSUM_EN
  logic [7:0]  sum_q, sum_d;
`endif

  logic              wr_en, rd_en, commit, last_wr;
  logic [LUT_AW-1:0] rd_addr;
  logic [7:0]        ram_rdata;

  gamma_shadow_ram u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (cnt_q[LUT_AW-1:0]),
    .wr_data (rx_byte),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rdata)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    rd_addr  = cnt_q[LUT_AW-1:0];
    rd_vld_d = 1'b0;
    rd_sop_d = 1'b0;
    rd_eop_d = 1'b0;
    commit   = 1'b0;
    last_wr  = 1'b0;
`ifdef GAMMA_LUT_CHKSUM_EN
    sum_d    = sum_q;
`endif

    // A byte arriving together with stop is processed before the stop.
    case (state_q)
      IDLE: if (rx_start) state_d = CMD;
      CMD: begin
        if (rx_start) state_d = CMD;
        else begin
          if (rx_vld) begin
            if (rx_byte == CMD_BYTE) begin
              state_d = DATA;
              cnt_d   = '0;
`ifdef GAMMA_LUT_CHKSUM_EN
              sum_d   = '0;
`endif
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
          end
          if (rx_stop) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (rx_start) state_d = CMD;
        else begin
          if (rx_vld) begin
            wr_en   = 1'b1;
            cnt_d   = cnt_q + 9'd1;
            last_wr = (cnt_q == CNT_LAST);
`ifdef GAMMA_LUT_CHKSUM_EN
            sum_d   = sum_q + rx_byte;
`endif
          end
          if (last_wr) begin
`ifdef GAMMA_LUT_CHKSUM_EN
            state_d = CHK;
            if (rx_stop) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end
`else
            if (rx_stop) commit = 1'b1;
            else         state_d = WAIT_STOP;
`endif
          end else if (rx_stop) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
`ifdef GAMMA_LUT_CHKSUM_EN
      CHK: begin
        if (rx_start) state_d = CMD;
        else if (rx_vld) begin
          if (rx_byte == sum_q) begin
            if (rx_stop) commit  = 1'b1;
            else         state_d = WAIT_STOP;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (rx_stop) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
`endif
      WAIT_STOP: begin
        if (rx_start) state_d = CMD;
        else if (rx_vld) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (rx_stop) commit = 1'b1;
      end
      TX: begin
        if (rx_start) err_d = 1'b1;
        if (!cnt_q[8]) begin
          rd_en    = 1'b1;
          rd_vld_d = 1'b1;
          rd_eop_d = (cnt_q == CNT_LAST);
          cnt_d    = cnt_q + 9'd1;
        end
        if (eop_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Entry 0 is read in the commit cycle so SOP lands two cycles after stop.
    if (commit) begin
      state_d  = TX;
      rd_en    = 1'b1;
      rd_addr  = '0;
      rd_vld_d = 1'b1;
      rd_sop_d = 1'b1;
      cnt_d    = 9'd1;
    end
  end

  always_comb begin
    vld_d  = rd_vld_q;
    sop_d  = rd_sop_q;
    eop_d  = rd_eop_q;
    pkt_d  = rd_vld_q ? ram_rdata : 8'h00;
    busy_d = (state_d == TX);
    done_d = (state_q == TX) && eop_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_sop_q <= 1'b0;
      rd_eop_q <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      vld_q    <= 1'b0;
      pkt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef GAMMA_LUT_CHKSUM_EN
      sum_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rd_vld_q <= rd_vld_d;
      rd_sop_q <= rd_sop_d;
      rd_eop_q <= rd_eop_d;
      sop_q    <= sop_d;
      eop_q    <= eop_d;
      vld_q    <= vld_d;
      pkt_q    <= pkt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef GAMMA_LUT_CHKSUM_EN
      sum_q    <= sum_d;
`endif
    end
  end

  assign SOP         = sop_q;
  assign EOP         = eop_q;
  assign VLD         = vld_q;
  assign packet_data = pkt_q;
  assign busy        = busy_q;
  assign load_done   = done_q;
  assign load_err    = err_q;

endmodule
